// File: rtl/control_alu_mdu_if.sv
// EX-stage ALU control bundle: decode inputs, ALU control and MUL/DIV sequencing outputs.
// The design drives it through the slave modport; the bench or pipeline uses master.
interface control_alu_mdu_if;
    logic       i_valid;
    logic       i_flush;
    logic [1:0] i_alu_op;
    logic [2:0] i_f3;
    logic [6:0] i_f7;
    logic       i_is_imm;
    logic [3:0] o_alu_ctl;
    logic       o_md_start;
    logic [2:0] o_md_op;
    logic       o_md_done;
    logic       o_stall;

    modport master (
        output i_valid, i_flush, i_alu_op, i_f3, i_f7, i_is_imm,
        input  o_alu_ctl, o_md_start, o_md_op, o_md_done, o_stall
    );

    modport slave (
        input  i_valid, i_flush, i_alu_op, i_f3, i_f7, i_is_imm,
        output o_alu_ctl, o_md_start, o_md_op, o_md_done, o_stall
    );
endinterface

// File: rtl/control_alu_mdu.sv
// EX-stage ALU control decode for RV32I, with optional RV32M MUL/DIV stall sequencing.
// Define ALU_CTL_MD_EN to enable M-op decode and the latency FSM; otherwise M outputs are tied 0.
module control_alu_mdu #(
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DIV_LAT = 32,
    parameter int unsigned CNT_W   = 6
) (
    input logic              i_clk,
    input logic              i_rst,
    control_alu_mdu_if.slave bus
);
    localparam logic [3:0] CtlAdd     = 4'd0;
    localparam logic [3:0] CtlSub     = 4'd1;
    localparam logic [3:0] CtlAnd     = 4'd2;
    localparam logic [3:0] CtlOr      = 4'd3;
    localparam logic [3:0] CtlXor     = 4'd4;
    localparam logic [3:0] CtlSll     = 4'd5;
    localparam logic [3:0] CtlSrl     = 4'd6;
    localparam logic [3:0] CtlSra     = 4'd7;
    localparam logic [3:0] CtlLessSig = 4'd8;
    localparam logic [3:0] CtlLessUns = 4'd9;

    logic [3:0] base_ctl;

    always_comb begin
        base_ctl = CtlAdd;
        case (bus.i_alu_op)
            2'b00: base_ctl = CtlAdd;
            2'b01: base_ctl = CtlSub;
            2'b11: begin
                case (bus.i_f3)
                    3'b000, 3'b001: base_ctl = CtlSub;
                    3'b100, 3'b101: base_ctl = CtlLessSig;
                    3'b110, 3'b111: base_ctl = CtlLessUns;
                    default:        base_ctl = CtlAdd;
                endcase
            end
            default: begin
                case (bus.i_f3)
                    // OP-IMM has no SUBI, so funct7 only matters for register ADD/SUB
                    3'b000:  base_ctl = (bus.i_is_imm || !bus.i_f7[5]) ? CtlAdd : CtlSub;
                    3'b001:  base_ctl = CtlSll;
                    3'b010:  base_ctl = CtlLessSig;
                    3'b011:  base_ctl = CtlLessUns;
                    3'b100:  base_ctl = CtlXor;
                    3'b101:  base_ctl = bus.i_f7[5] ? CtlSra : CtlSrl;
                    3'b110:  base_ctl = CtlOr;
                    default: base_ctl = CtlAnd;
                endcase
            end
        endcase
    end

`ifdef ALU_CTL_MD_EN
    localparam logic [3:0]       CtlMd  = 4'd15;
    localparam logic [CNT_W-1:0] MulCnt = CNT_W'(MUL_LAT - 2);
    localparam logic [CNT_W-1:0] DivCnt = CNT_W'(DIV_LAT - 2);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       md_op_q;
    logic             m_op;
    logic             accept;

    assign m_op   = (bus.i_alu_op == 2'b10) && !bus.i_is_imm && (bus.i_f7 == 7'b0000001);
    assign accept = (state_q == StIdle) && bus.i_valid && m_op && !bus.i_flush && !i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            md_op_q <= 3'b000;
        end else if (bus.i_flush) begin
            state_q <= StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        md_op_q <= bus.i_f3;
                        cnt_q   <= bus.i_f3[2] ? DivCnt : MulCnt;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q <= StDone;
                    end
                end
                // The held instruction is still on the inputs here, so never re-accept
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.o_alu_ctl  = i_rst ? CtlAdd : (m_op ? CtlMd : base_ctl);
    assign bus.o_md_start = accept;
    assign bus.o_md_op    = md_op_q;
    assign bus.o_stall    = !i_rst && !bus.i_flush && (accept || (state_q == StBusy));
    assign bus.o_md_done  = !i_rst && !bus.i_flush && (state_q == StDone);
`else
    logic unused_inputs;

    assign unused_inputs  = ^{i_clk, bus.i_valid, bus.i_flush, bus.i_f7[6], bus.i_f7[4:0]};
    assign bus.o_alu_ctl  = i_rst ? CtlAdd : base_ctl;
    assign bus.o_md_start = 1'b0;
    assign bus.o_md_op    = 3'b000;
    assign bus.o_stall    = 1'b0;
    assign bus.o_md_done  = 1'b0;
`endif
endmodule
